// File: rtl/acc_step_core.sv
// acc_step_core: single-stepped 8-bit accumulator processor fetching 16-bit words from a synchronous ROM.
//   Build option: define ACC_SUB_EN to decode opcode 4 as SUBI (otherwise it is a NOP).
//   Ports:
//     clk      - system clock, shared with the ROM
//     rst      - synchronous active-high reset
//     step     - advance request, sampled only in IDLE
//     rom_addr - program counter presented to the ROM
//     rom_data - ROM word, valid one cycle after rom_addr
//     leds     - output register written by OUT
//     halted   - high once HALT has executed
module acc_step_core #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        leds,
    output logic              halted
);
    typedef enum logic [1:0] {IDLE, MEM, EXEC, HALTED} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        acc_q, acc_d;
    logic              z_q, z_d;
    logic [7:0]        leds_q, leds_d;
    logic [3:0]        op;
    logic [7:0]        imm;
    logic [7:0]        sum;
    logic [ADDR_W-1:0] tgt;
    logic              unused_bits;
    assign op          = rom_data[15:12];
    assign imm         = rom_data[7:0];
    assign sum         = acc_q + imm;
    assign tgt         = ADDR_W'(rom_data[9:0]);
    assign unused_bits = ^rom_data[11:10];
`ifdef ACC_SUB_EN
    logic [7:0] diff;
    assign diff = acc_q - imm;
`endif
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        z_d     = z_q;
        leds_d  = leds_q;
        case (state_q)
            IDLE: state_d = step ? MEM : IDLE;
            MEM:  state_d = EXEC;
            EXEC: begin
                state_d = IDLE;
                pc_d    = pc_q + ADDR_W'(1);
                case (op)
                    4'h1: begin
                        state_d = HALTED;
                        pc_d    = pc_q;
                    end
                    4'h2: begin
                        acc_d = imm;
                        z_d   = (imm == 8'h00);
                    end
                    4'h3: begin
                        acc_d = sum;
                        z_d   = (sum == 8'h00);
                    end
`ifdef ACC_SUB_EN
                    4'h4: begin
                        acc_d = diff;
                        z_d   = (diff == 8'h00);
                    end
`endif
                    4'h5: leds_d = acc_q;
                    4'h6: pc_d = tgt;
                    4'h7: pc_d = z_q ? tgt : pc_q + ADDR_W'(1);
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            acc_q   <= 8'h00;
            z_q     <= 1'b0;
            leds_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
            leds_q  <= leds_d;
        end
    end
    assign rom_addr = pc_q;
    assign leds     = leds_q;
    assign halted   = (state_q == HALTED);
endmodule

// File: tb/tb_acc_step_core.sv
// tb_acc_step_core: directed self-checking bench for acc_step_core with a synchronous ROM model.
module tb_acc_step_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        step = 1'b0;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic [7:0]  leds;
    logic        halted;
    logic [15:0] rom [1024];
    int          nvec = 0;
    int          nerr = 0;

    acc_step_core #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .step(step), .rom_addr(rom_addr),
        .rom_data(rom_data), .leds(leds), .halted(halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        step = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_rom();
        do_reset();
        nvec++; if (rom_addr !== 10'd0) begin nerr++; $display("FAIL reset_addr got %0d want 0", rom_addr); end
        nvec++; if (leds !== 8'h00) begin nerr++; $display("FAIL reset_leds got %h want 00", leds); end
        nvec++; if (halted !== 1'b0) begin nerr++; $display("FAIL reset_halted got %b want 0", halted); end
    endtask

    task automatic test_out_halt();
        clear_rom();
        rom[0] = 16'h2005; rom[1] = 16'h5000; rom[2] = 16'h1000;
        do_reset();
        step = 1'b1;
        tick(5);
        nvec++; if (leds !== 8'h00) begin nerr++; $display("FAIL out_early got %h want 00", leds); end
        tick(1);
        nvec++; if (leds !== 8'h05) begin nerr++; $display("FAIL out_leds got %h want 05", leds); end
        tick(2);
        nvec++; if (halted !== 1'b0) begin nerr++; $display("FAIL halt_early got %b want 0", halted); end
        tick(1);
        nvec++; if (halted !== 1'b1) begin nerr++; $display("FAIL halt_rise got %b want 1", halted); end
        tick(6);
        nvec++; if (rom_addr !== 10'd2) begin nerr++; $display("FAIL halt_pc got %0d want 2", rom_addr); end
        nvec++; if (halted !== 1'b1) begin nerr++; $display("FAIL halt_sticky got %b want 1", halted); end
        step = 1'b0;
        do_reset();
        nvec++; if (halted !== 1'b0 || rom_addr !== 10'd0) begin nerr++; $display("FAIL halt_reset got halted=%b addr=%0d want 0/0", halted, rom_addr); end
    endtask

    task automatic test_jz();
        clear_rom();
        rom[0] = 16'h20FF; rom[1] = 16'h3001; rom[2] = 16'h7005;
        rom[3] = 16'h2011; rom[4] = 16'h5000;
        rom[5] = 16'h5000; rom[6] = 16'h2077; rom[7] = 16'h5000; rom[8] = 16'h1000;
        do_reset();
        step = 1'b1;
        tick(9);
        nvec++; if (rom_addr !== 10'd5) begin nerr++; $display("FAIL jz_taken got %0d want 5", rom_addr); end
        tick(3);
        nvec++; if (leds !== 8'h00) begin nerr++; $display("FAIL jz_acc_zero got %h want 00", leds); end
        tick(9);
        nvec++; if (leds !== 8'h77) begin nerr++; $display("FAIL jz_tail_leds got %h want 77", leds); end
        nvec++; if (halted !== 1'b1 || rom_addr !== 10'd8) begin nerr++; $display("FAIL jz_halt got halted=%b addr=%0d want 1/8", halted, rom_addr); end
        step = 1'b0;
    endtask

    task automatic test_step_pulse();
        clear_rom();
        do_reset();
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(5);
        nvec++; if (rom_addr !== 10'd1) begin nerr++; $display("FAIL pulse_one got %0d want 1", rom_addr); end
        step = 1'b1;
        tick(3);
        step = 1'b0;
        tick(6);
        nvec++; if (rom_addr !== 10'd2) begin nerr++; $display("FAIL pulse_extra got %0d want 2", rom_addr); end
    endtask

    task automatic test_wrap();
        clear_rom();
        do_reset();
        step = 1'b1;
        tick(3 * 1023);
        nvec++; if (rom_addr !== 10'd1023) begin nerr++; $display("FAIL wrap_top got %0d want 1023", rom_addr); end
        tick(3);
        nvec++; if (rom_addr !== 10'd0) begin nerr++; $display("FAIL wrap_zero got %0d want 0", rom_addr); end
        nvec++; if (leds !== 8'h00 || halted !== 1'b0) begin nerr++; $display("FAIL wrap_state got leds=%h halted=%b want 00/0", leds, halted); end
        step = 1'b0;
    endtask

    task automatic test_subi();
        logic [7:0] exp_leds;
        logic [9:0] exp_addr;
`ifdef ACC_SUB_EN
        exp_leds = 8'h00; exp_addr = 10'd6;
`else
        exp_leds = 8'h03; exp_addr = 10'd4;
`endif
        clear_rom();
        rom[0] = 16'h2003; rom[1] = 16'h4003; rom[2] = 16'h5000;
        rom[3] = 16'h7006; rom[4] = 16'h1000; rom[6] = 16'h1000;
        do_reset();
        step = 1'b1;
        tick(15);
        step = 1'b0;
        nvec++; if (leds !== exp_leds) begin nerr++; $display("FAIL subi_leds got %h want %h", leds, exp_leds); end
        nvec++; if (rom_addr !== exp_addr || halted !== 1'b1) begin nerr++; $display("FAIL subi_z got addr=%0d halted=%b want %0d/1", rom_addr, halted, exp_addr); end
    endtask

    task automatic test_rst_exec();
        clear_rom();
        rom[0] = 16'h2042; rom[1] = 16'h5000;
        do_reset();
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        nvec++; if (rom_addr !== 10'd0 || leds !== 8'h00) begin nerr++; $display("FAIL rst_exec got addr=%0d leds=%h want 0/00", rom_addr, leds); end
        rom[0] = 16'h3001;
        step = 1'b1;
        tick(6);
        step = 1'b0;
        nvec++; if (leds !== 8'h01) begin nerr++; $display("FAIL rst_exec_acc got %h want 01", leds); end
        nvec++; if (rom_addr !== 10'd2) begin nerr++; $display("FAIL rst_exec_pc got %0d want 2", rom_addr); end
    endtask

    task automatic test_rst_step();
        clear_rom();
        do_reset();
        step = 1'b1;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        step = 1'b0;
        tick(4);
        nvec++; if (rom_addr !== 10'd0) begin nerr++; $display("FAIL rst_step got %0d want 0", rom_addr); end
    endtask

    initial begin
        test_reset();
        test_out_halt();
        test_jz();
        test_step_pulse();
        test_wrap();
        test_subi();
        test_rst_exec();
        test_rst_step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/acc_step_core.md
# acc_step_core

Minimal accumulator processor that consumes the 16-bit words produced by the 1K×16 program ROM. It drives the ROM address as its program counter, decodes each returned word, and executes it against an 8-bit accumulator, with the result shown on the 8 LEDs. Execution advances one instruction per `step` request, so the existing debounced push-button and prescaler can single-step it or free-run it.

## Interface
- `ADDR_W`, default 10: program counter / ROM address width (1K words).
- `clk`  in  1: system clock; the ROM is clocked from the same net.
- `rst`  in  1: reset; one clock; reset is synchronous and active-high.
- `step`  in  1: advance request; sampled only in IDLE; a level held high free-runs.
- `rom_addr`  out  ADDR_W: program counter presented to the ROM.
- `rom_data`  in  16: ROM word, valid one `clk` cycle after `rom_addr` is stable.
- `leds`  out  8: output register, written only by OUT.
- `halted`  out  1: high once HALT has executed.

## Operation
- Instruction word: opcode = `rom_data[15:12]`, imm8 = `[7:0]`, target = `[9:0]`.
- 0 NOP: no effect.
- 1 HALT: enter HALTED.
- 2 LDI: A ← imm8.
- 3 ADDI: A ← (A + imm8) mod 256.
- 4 SUBI (macro-gated): A ← (A − imm8) mod 256.
- 5 OUT: `leds` ← A.
- 6 JP: pc ← target.
- 7 JZ: pc ← target if Z = 1, else pc + 1.
- 8–F: NOP.
- Z ← (result == 0) on LDI, ADDI and SUBI only; every other opcode leaves Z unchanged.
- pc ← pc + 1 mod 2^ADDR_W for all opcodes except a taken JP/JZ and HALT. pc 1023 wraps to 0.
- FSM states: IDLE, MEM, EXEC, HALTED.
  - IDLE: if `step` = 1, go to MEM; otherwise stay.
  - MEM: ROM read cycle; `rom_data` is ignored; go to EXEC.
  - EXEC: latch and execute `rom_data`; go to IDLE, or to HALTED for HALT.
  - HALTED: absorbing; only `rst` leaves it.
- `rom_addr` = pc at all times; pc changes only at the end of EXEC.

## Timing
- Reset values: state = IDLE, pc = 0, A = 0x00, Z = 0, `leds` = 0x00, `halted` = 0, `rom_addr` = 0.
- One instruction takes 3 cycles (IDLE→MEM→EXEC). With `step` held at 1, the core issues one instruction every 3 cycles.
- A 1-cycle `step` pulse seen in IDLE executes exactly one instruction. `step` in MEM, EXEC or HALTED is ignored and not queued.
- Register updates (A, Z, `leds`, pc) land on the clock edge that ends EXEC.
  - OUT: `leds` is visible 1 cycle after EXEC.
  - HALT: `halted` rises 1 cycle after EXEC.
- `rst` asserted in any state, including mid-instruction in MEM or EXEC, wins over everything on that edge. The in-flight instruction is discarded with no partial writes.
- `rst` and `step` high on the same edge: reset wins; state = IDLE.

## Configuration
- `ACC_SUB_EN` defined: opcode 4 is SUBI as specified; Z is updated from the result.
- `ACC_SUB_EN` undefined: opcode 4 decodes as NOP; A and Z are untouched; no subtractor is synthesised.

## Test plan
- Reset, then hold `step` = 1 with ROM {0x2005, 0x5000, 0x1000} → `leds` = 0x05 after cycle 6; `halted` = 1 after cycle 9; pc frozen at 2.
- ROM {0x20FF, 0x3001, 0x7005 …}, location 5 = 0x5000 → A = 0x00, Z = 1, JZ taken, `rom_addr` = 5.
- Single 1-cycle `step` pulses from reset → `rom_addr` increments by exactly 1 per pulse. An extra pulse during MEM or EXEC is ignored.
- ROM all 0x0000 with free-run `step` → `rom_addr` goes 1023 → 0; A, Z and `leds` are unchanged.
- With `ACC_SUB_EN`, ROM {0x2003, 0x4003, 0x5000} → `leds` = 0x00, Z = 1. Without the macro → `leds` = 0x03, Z = 0.
- `rst` pulsed during EXEC of 0x2042 → A = 0x00, pc = 0, state IDLE on the next cycle.
